// File: rtl/obi_resp_pkg.sv
// Shared constants, response pipeline entry and address decode for the OBI data responder.
package obi_resp_pkg;

   localparam logic [31:0] TEST_CTRL_ADDR = 32'h2000_0000;
   localparam logic [31:0] EXIT_ADDR      = 32'h2000_0004;
   localparam logic [31:0] PASS_MAGIC     = 32'd123456789;
   localparam logic [31:0] FAIL_MAGIC     = 32'd1;
   localparam logic [31:0] BAD_RDATA      = 32'hDEAD_BEEF;
   localparam logic [15:0] LFSR_SEED      = 16'hACE1;

   typedef enum logic [1:0] {REG_RAM, REG_CTRL, REG_EXIT, REG_NONE} addr_region_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
   } resp_t;

   // Register decode ignores addr[1:0], matching the RAM's word selection.
   function automatic addr_region_e decode_addr(input logic [31:0] addr, input int unsigned mem_aw);
      if ((addr >> mem_aw) == 32'd0)             return REG_RAM;
      if (addr[31:2] == TEST_CTRL_ADDR[31:2])    return REG_CTRL;
      if (addr[31:2] == EXIT_ADDR[31:2])         return REG_EXIT;
      return REG_NONE;
   endfunction

endpackage

// File: rtl/obi_data_responder_if.sv
// Core data port (req/gnt/rvalid) as seen between the RI5CY core and its responder.
interface obi_data_responder_if;
   logic        data_req;
   logic [31:0] data_addr;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_addr, data_we, data_be, data_wdata,
      input  data_gnt, data_rvalid, data_rdata
   );

   modport slave (
      input  data_req, data_addr, data_we, data_be, data_wdata,
      output data_gnt, data_rvalid, data_rdata
   );
endinterface

// File: rtl/obi_resp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to inject random grant stalls.
module obi_resp_lfsr
   import obi_resp_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obi_data_responder.sv
// Slave end of the RI5CY data port: scratch RAM, exit/status registers, programmable gnt/rvalid latency.
// Define OBI_RESP_RANDOM_STALL_EN to add LFSR-driven random grant stalls.
module obi_data_responder
   import obi_resp_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int GNT_DELAY      = 0,
   parameter int RVALID_DELAY   = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   obi_data_responder_if.slave  bus,
   output logic                 tests_passed_o,
   output logic                 tests_failed_o,
   output logic                 exit_valid_o,
   output logic [31:0]          exit_value_o
);

   localparam int WORDS = 2 ** (MEM_ADDR_WIDTH - 2);

   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic        gnt, stall;
   logic        passed_q, passed_d, failed_q, failed_d;
   logic        exit_valid_q, exit_valid_d;
   logic [31:0] exit_value_q, exit_value_d;
   logic [31:0] rdata_sel;
   logic [31:0] mem [WORDS];
   logic [MEM_ADDR_WIDTH-3:0] word_idx;
   addr_region_e              region;
   resp_t [RVALID_DELAY-1:0]  pipe_q, pipe_d;

`ifdef OBI_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   obi_resp_lfsr u_lfsr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (1'b1),
      .lfsr_o (lfsr)
   );

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign gnt           = bus.data_req & (wait_cnt_q == 4'(GNT_DELAY)) & ~stall;
   assign bus.data_gnt  = gnt;
   assign region        = decode_addr(bus.data_addr, MEM_ADDR_WIDTH);
   assign word_idx      = bus.data_addr[MEM_ADDR_WIDTH-1:2];

   // Counts held-req cycles; a stalled grant leaves it parked at GNT_DELAY.
   always_comb begin
      wait_cnt_d = '0;
      if (bus.data_req && !gnt)
         wait_cnt_d = (wait_cnt_q == 4'(GNT_DELAY)) ? wait_cnt_q : wait_cnt_q + 4'd1;
   end

   always_comb begin
      passed_d     = passed_q;
      failed_d     = failed_q;
      exit_valid_d = exit_valid_q;
      exit_value_d = exit_value_q;
      if (gnt && bus.data_we) begin
         unique case (region)
            REG_CTRL: begin
               if (bus.data_wdata == PASS_MAGIC)      passed_d = 1'b1;
               else if (bus.data_wdata == FAIL_MAGIC) failed_d = 1'b1;
            end
            REG_EXIT: begin
               exit_value_d = bus.data_wdata;
               exit_valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_sel = BAD_RDATA;
      unique case (region)
         REG_RAM:  rdata_sel = mem[word_idx];
         REG_EXIT: rdata_sel = exit_value_q;
         REG_CTRL: rdata_sel = '0;
         default:  rdata_sel = BAD_RDATA;
      endcase
   end

   always_comb begin
      pipe_d          = pipe_q;
      pipe_d[0].valid = gnt;
      pipe_d[0].rdata = (gnt && !bus.data_we) ? rdata_sel : '0;
      for (int i = 1; i < RVALID_DELAY; i++) pipe_d[i] = pipe_q[i-1];
   end

   // RAM has no reset; a write lands on the accept edge so the next accept reads it back.
   always_ff @(posedge clk_i) begin
      if (gnt && bus.data_we && region == REG_RAM)
         for (int b = 0; b < 4; b++)
            if (bus.data_be[b]) mem[word_idx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q   <= '0;
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         exit_valid_q <= 1'b0;
         exit_value_q <= '0;
         pipe_q       <= '0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         passed_q     <= passed_d;
         failed_q     <= failed_d;
         exit_valid_q <= exit_valid_d;
         exit_value_q <= exit_value_d;
         pipe_q       <= pipe_d;
      end
   end

   assign bus.data_rvalid = pipe_q[RVALID_DELAY-1].valid;
   assign bus.data_rdata  = pipe_q[RVALID_DELAY-1].rdata;
   assign tests_passed_o  = passed_q;
   assign tests_failed_o  = failed_q;
   assign exit_valid_o    = exit_valid_q;
   assign exit_value_o    = exit_value_q;

endmodule
